// File: rtl/lap_stop_watch.sv
// rtl/lap_stop_watch.sv - BCD MM:SS.cc stopwatch with prescaler, overflow policy and lap-time FIFO
module lap_stop_watch #(
    parameter int TICK_DIV  = 500000,
    parameter int LAP_DEPTH = 4,
    parameter bit WRAP      = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           start_stop,
    input  logic                           clear,
    input  logic                           lap,
    input  logic                           lap_rd,
    output logic [23:0]                    time_bcd,
    output logic                           running,
    output logic [23:0]                    lap_bcd,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_empty,
    output logic                           lap_full,
    output logic                           ovf
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = $clog2(LAP_DEPTH + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [23:0]   MAX_TIME = 24'h995999;

    logic [PW-1:0] pre_cnt;
    logic [23:0]   lap_mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          counting;
    logic          tick;
    logic          advance;
    logic          do_push;
    logic          do_pop;
    logic [AW-1:0] rd_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [23:0]   head_nxt;

    // Increment MM:SS.cc; the tens-of-seconds digit is the only one rolling over at 5.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  lim;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3) ? 4'd5 : 4'd9;
            if (carry) begin
                if (r[4*i +: 4] == lim) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        counting = running && enable;
        tick     = counting && (pre_cnt == PRE_LAST);
        // Once saturated, time must not move again until clear.
        advance  = tick && !(ovf && !WRAP);
        do_pop   = enable && lap_rd && (lap_count != '0);
        do_push  = enable && lap && ((lap_count != CW'(LAP_DEPTH)) || do_pop);
        rd_nxt   = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        cnt_nxt  = lap_count + CW'(do_push) - CW'(do_pop);
        // A push landing in the slot that becomes the head is not in lap_mem yet.
        if (cnt_nxt == '0) begin
            head_nxt = 24'h0;
        end else if (do_push && (rd_nxt == wr_ptr)) begin
            head_nxt = time_bcd;
        end else begin
            head_nxt = lap_mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            lap_mem[wr_ptr] <= time_bcd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            time_bcd  <= 24'h0;
            running   <= 1'b0;
            ovf       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lap_count <= '0;
            lap_bcd   <= 24'h0;
            lap_empty <= 1'b1;
            lap_full  <= 1'b0;
        end else if (clear) begin
            pre_cnt   <= '0;
            time_bcd  <= 24'h0;
            running   <= 1'b0;
            ovf       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lap_count <= '0;
            lap_bcd   <= 24'h0;
            lap_empty <= 1'b1;
            lap_full  <= 1'b0;
        end else begin
            if (counting) begin
                pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            end
            if (advance) begin
                if (time_bcd == MAX_TIME) begin
                    ovf <= 1'b1;
                    if (WRAP) begin
                        time_bcd <= 24'h0;
                    end else begin
                        running <= 1'b0;
                    end
                end else begin
                    time_bcd <= bcd_inc(time_bcd);
                end
            end
            if (enable && start_stop) begin
                running <= ~running;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_nxt;
            lap_count <= cnt_nxt;
            lap_bcd   <= head_nxt;
            lap_empty <= (cnt_nxt == '0);
            lap_full  <= (cnt_nxt == CW'(LAP_DEPTH));
        end
    end

endmodule

// File: tb/tb_lap_stop_watch.sv
// tb/tb_lap_stop_watch.sv - stopwatch bench: centisecond/queue reference model plus directed and random stimulus
module tb_lap_stop_watch;

    localparam int TD = 2;
    localparam int LD = 4;
    localparam int MAX_CS = 599999;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic start_stop = 1'b0;
    logic clear = 1'b0;
    logic lap = 1'b0;
    logic lap_rd = 1'b0;

    logic [23:0] time_bcd, lap_bcd, s_time, s_lap_bcd;
    logic [2:0]  lap_count, s_cnt;
    logic        running, lap_empty, lap_full, ovf;
    logic        s_run, s_empty, s_full, s_ovf;
    logic [23:0] force_val;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    int          m_cs = 0;
    int          m_pre = 0;
    bit          m_run = 1'b0;
    bit          m_ovf = 1'b0;
    logic [23:0] m_q[$];

    lap_stop_watch #(.TICK_DIV(TD), .LAP_DEPTH(LD), .WRAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start_stop(start_stop), .clear(clear),
        .lap(lap), .lap_rd(lap_rd), .time_bcd(time_bcd), .running(running), .lap_bcd(lap_bcd),
        .lap_count(lap_count), .lap_empty(lap_empty), .lap_full(lap_full), .ovf(ovf)
    );

    lap_stop_watch #(.TICK_DIV(TD), .LAP_DEPTH(LD), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start_stop(start_stop), .clear(clear),
        .lap(lap), .lap_rd(lap_rd), .time_bcd(s_time), .running(s_run), .lap_bcd(s_lap_bcd),
        .lap_count(s_cnt), .lap_empty(s_empty), .lap_full(s_full), .ovf(s_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic int from_bcd(input logic [23:0] b);
        return (int'(b[23:20]) * 10 + int'(b[19:16])) * 6000
             + (int'(b[15:12]) * 10 + int'(b[11:8])) * 100
             + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: elapsed time as plain centiseconds, laps as a queue.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || clear) begin
                m_cs = 0; m_pre = 0; m_run = 0; m_ovf = 0; m_q.delete();
            end else begin
                logic [23:0] cur;
                bit tk, pop, push;
                cur = to_bcd(m_cs);
                tk = m_run && enable && (m_pre == TD - 1);
                if (m_run && enable) m_pre = (m_pre + 1) % TD;
                if (tk) begin
                    if (m_cs == MAX_CS) begin
                        m_cs = 0; m_ovf = 1;
                    end else begin
                        m_cs++;
                    end
                end
                if (enable && start_stop) m_run = !m_run;
                if (enable) begin
                    pop  = lap_rd && (m_q.size() > 0);
                    push = lap && ((m_q.size() < LD) || pop);
                    if (pop) void'(m_q.pop_front());
                    if (push) m_q.push_back(cur);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("time", time_bcd, to_bcd(m_cs));
                chk("running", running, m_run);
                chk("ovf", ovf, m_ovf);
                chk("lap_bcd", lap_bcd, (m_q.size() > 0) ? m_q[0] : 24'h0);
                chk("lap_count", lap_count, m_q.size());
                chk("lap_empty", lap_empty, m_q.size() == 0);
                chk("lap_full", lap_full, m_q.size() == LD);
            end
        end
    end

    // All stimulus tasks start and end just after a falling edge.
    task automatic pulse(input bit ss, input bit cl, input bit lp, input bit rd);
        start_stop = ss; clear = cl; lap = lp; lap_rd = rd;
        @(negedge clk);
        start_stop = 0; clear = 0; lap = 0; lap_rd = 0;
    endtask

    task automatic set_time(input logic [23:0] v);
        #2;
        force_val = v;
        force dut.time_bcd = force_val;
        force u_sat.time_bcd = force_val;
        #1;
        release dut.time_bcd;
        release u_sat.time_bcd;
        m_cs = from_bcd(v);
        @(negedge clk);
    endtask

    logic [23:0] lv [5];
    int n;

    initial begin
        lv[0] = 24'h000012; lv[1] = 24'h000034; lv[2] = 24'h000056;
        lv[3] = 24'h000078; lv[4] = 24'h000090;

        #12;
        chk("rst_time", time_bcd, 24'h0);
        chk("rst_running", running, 0);
        chk("rst_lap_bcd", lap_bcd, 24'h0);
        chk("rst_count", lap_count, 0);
        chk("rst_empty", lap_empty, 1);
        chk("rst_full", lap_full, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1;
        chk_en = 1;

        pulse(1, 0, 0, 0);
        repeat (200) @(negedge clk);
        chk("t1_time", time_bcd, 24'h000100);
        chk("t1_running", running, 1);
        pulse(1, 0, 0, 0);
        repeat (10) @(negedge clk);
        chk("t1_frozen", time_bcd, 24'h000100);
        chk("t1_stopped", running, 0);

        pulse(1, 0, 0, 0);
        @(negedge clk);
        chk("t2_resume_tick", time_bcd, 24'h000101);
        n = 0;
        while (time_bcd !== 24'h005999 && n < 15000) begin @(negedge clk); n++; end
        chk("t2_reach_5999", time_bcd, 24'h005999);
        n = 0;
        while (time_bcd === 24'h005999 && n < 10) begin @(negedge clk); n++; end
        chk("t2_minute_carry", time_bcd, 24'h010000);
        pulse(1, 0, 0, 0);
        repeat (5) @(negedge clk);
        chk("t2_stop_hold", time_bcd, 24'h010000);
        pulse(1, 0, 0, 0);
        @(negedge clk);
        chk("t2_partial_tick", time_bcd, 24'h010001);

        pulse(0, 1, 0, 0);
        set_time(24'h995999);
        pulse(1, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("t3_wrap_time", time_bcd, 24'h000000);
        chk("t3_wrap_ovf", ovf, 1);
        chk("t3_wrap_run", running, 1);
        chk("t3_sat_time", s_time, 24'h995999);
        chk("t3_sat_ovf", s_ovf, 1);
        chk("t3_sat_run", s_run, 0);
        pulse(1, 0, 0, 0);
        repeat (6) @(negedge clk);
        chk("t3_sat_hold", s_time, 24'h995999);
        chk("t3_sat_rerun", s_run, 1);

        pulse(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            set_time(lv[i]);
            pulse(0, 0, 1, 0);
        end
        chk("t4_full", lap_full, 1);
        chk("t4_count", lap_count, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t4_pop_order", lap_bcd, lv[i]);
            pulse(0, 0, 0, 1);
        end
        chk("t4_empty", lap_empty, 1);
        chk("t4_empty_bcd", lap_bcd, 24'h0);
        pulse(0, 0, 0, 1);
        chk("t4_extra_rd", lap_count, 0);

        for (int i = 0; i < 4; i++) begin
            set_time(lv[i]);
            pulse(0, 0, 1, 0);
        end
        set_time(24'h000099);
        pulse(0, 0, 1, 1);
        chk("t5_full_count", lap_count, 4);
        chk("t5_full_head", lap_bcd, 24'h000034);
        repeat (3) pulse(0, 0, 0, 1);
        chk("t5_tail", lap_bcd, 24'h000099);
        pulse(0, 1, 0, 0);
        set_time(24'h000042);
        pulse(0, 0, 1, 1);
        chk("t5_empty_count", lap_count, 1);
        chk("t5_empty_head", lap_bcd, 24'h000042);

        set_time(24'h995999);
        pulse(1, 0, 0, 0);
        repeat (2) @(negedge clk);
        pulse(1, 1, 1, 0);
        chk("t6_clr_time", time_bcd, 24'h0);
        chk("t6_clr_run", running, 0);
        chk("t6_clr_ovf", ovf, 0);
        chk("t6_clr_empty", lap_empty, 1);
        pulse(1, 0, 0, 0);
        repeat (7) @(negedge clk);
        enable = 0;
        pulse(1, 0, 0, 0);
        repeat (10) @(negedge clk);
        chk("t6_en_frozen", time_bcd, 24'h000003);
        chk("t6_en_running", running, 1);
        enable = 1;
        @(negedge clk);
        chk("t6_en_resume", time_bcd, 24'h000004);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("t6_arst_time", time_bcd, 24'h0);
        chk("t6_arst_run", running, 0);
        chk("t6_arst_empty", lap_empty, 1);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 4000; i++) begin
            if (i % 1000 == 500) begin
                start_stop = 0; clear = 0; lap = 0; lap_rd = 0;
                set_time(to_bcd(MAX_CS - 9 + int'($urandom_range(0, 9))));
            end
            enable     = ($urandom_range(0, 9) != 0);
            start_stop = ($urandom_range(0, 7) == 0);
            clear      = ($urandom_range(0, 149) == 0);
            lap        = ($urandom_range(0, 4) == 0);
            lap_rd     = ($urandom_range(0, 4) == 0);
            @(negedge clk);
        end
        start_stop = 0; clear = 0; lap = 0; lap_rd = 0; enable = 1;
        @(negedge clk);
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
